trigger_debouncer: RTL and testbench
====================================

# trigger_debouncer

- Conditions a raw, bouncing, asynchronous push-button input into a clean single-cycle `trigger` pulse.
- Sits directly upstream of the 2-bit up-counter and drives its `trigger` input, so one physical press advances the counter by exactly one.
- Also provides a debounced level output.
- Optionally generates auto-repeat pulses while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, default 25_000_000: auto-repeat period while held. Used only when auto-repeat is compiled in. Must be ≥ 2.
- `clk`  input  1  single system clock; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 resets the block.
- `btn`  input  1  raw button, asynchronous to `clk`, active-high, may bounce.
- `trigger`  output  1  registered pulse, high for exactly one `clk` cycle per accepted event.
- `btn_db`  output  1  registered debounced level of `btn`.

## Operation
- **Synchronizer:** 2-flop chain `btn` → `s1` → `btn_sync`. The FSM uses only `btn_sync`.
- **Counters:**
  - Debounce counter: width `$clog2(DEBOUNCE_CYCLES)`.
  - Repeat counter: width `$clog2(REPEAT_CYCLES)`.
  - Both saturate-free; they are cleared on every state entry.
- **FSM states:** IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - **IDLE** (`btn_db`=0): `btn_sync`=1 → WAIT_PRESS, counter cleared to 0.
  - **WAIT_PRESS:**
    - `btn_sync`=0 → IDLE. Bounce rejected; no pulse.
    - `btn_sync`=1 and cnt≠N-1 → cnt+1.
    - `btn_sync`=1 and cnt=N-1 → PRESSED. `trigger`=1 next cycle; `btn_db`=1.
  - **PRESSED** (`btn_db`=1): `btn_sync`=0 → WAIT_RELEASE, counter cleared.
  - **WAIT_RELEASE:**
    - `btn_sync`=1 → PRESSED. Release bounce rejected; no new press pulse; `btn_db` stays 1.
    - `btn_sync`=0 and cnt=N-1 → IDLE; `btn_db`=0.
- `trigger` is asserted only on the WAIT_PRESS→PRESSED transition (and on auto-repeat, see Configuration). A release never pulses.
- N = `DEBOUNCE_CYCLES`.

## Timing
- **Reset:** `reset`=0 at a rising edge forces state=IDLE, both counters=0, `s1`=`btn_sync`=0, `trigger`=0, `btn_db`=0.
- **Press latency:** `btn` stably high, first sampled at edge E0:
  - `btn_sync`=1 after E1.
  - WAIT_PRESS entered at E2.
  - PRESSED entered at E(N+2); `trigger` and `btn_db` go high after E(N+2).
  - `trigger` returns low after E(N+3).
- **Release latency:** `btn` stably low from E0 → `btn_db` falls after E(N+2).
- **Bounce:** any opposite sample in a WAIT state restarts the process. The full N stable cycles are required again.
- **Reset mid-operation:** all state is lost. If `btn` is still held after reset deasserts, it is treated as a fresh press and yields one `trigger` N+2 cycles later.
- **Reset vs. transition:** a reset asserted on the same edge as a would-be transition wins; no pulse is emitted.
- **Downstream:** `trigger` never stays high for 2 consecutive cycles, so the downstream counter advances by at most 1 per event.

## Configuration
- Macro: `TRIGGER_DEBOUNCER_AUTOREPEAT_EN`.
- **Defined:**
  - While in PRESSED, the repeat counter increments each cycle.
  - When it reaches `REPEAT_CYCLES`-1, `trigger` pulses for 1 cycle and the counter clears.
  - First repeat pulse comes `REPEAT_CYCLES` cycles after the press pulse, then every `REPEAT_CYCLES` cycles.
  - The repeat counter clears on every entry to PRESSED, including re-entry from WAIT_RELEASE.
  - The repeat counter holds 0 in all other states.
- **Undefined:**
  - No repeat counter is synthesized.
  - Exactly one `trigger` per accepted press, regardless of hold time.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=8, `REPEAT_CYCLES`=20.
1. **Reset:** `reset`=0 for 3 cycles with `btn`=1 → `trigger`=0, `btn_db`=0 throughout. Release reset with `btn` held → exactly one `trigger` pulse 10 edges later.
2. **Clean press:** `btn` 0→1 at E0, held 40 cycles →
   - `trigger` high only in the cycle after E10.
   - `btn_db`=1 from E10.
   - Release → `btn_db`=0 10 edges after the first low sample; no pulse on release.
3. **Bounce:** `btn` toggles 1,0,1,1,0,1 (1-cycle intervals), then stays high → no pulse during toggling. Single pulse 10 edges after the final rising sample.
4. **Release bounce:** while held, `btn` goes low for 3 cycles then high again → `btn_db` stays 1 and `trigger` stays 0 (without the macro).
5. **Glitch rejection:** press shorter than 8 stable cycles (7-cycle high pulse) → `trigger`=0, `btn_db`=0.
6. **Auto-repeat (macro defined):** hold `btn` for 70 cycles after the press pulse at cycle P → pulses at P, P+20, P+40, P+60. With the macro undefined → only the pulse at P.

Source files
------------

// File: rtl/trigger_debouncer.sv
// rtl/trigger_debouncer.sv - push-button synchronizer, debouncer and single-cycle trigger generator
//
// Turns a raw, bouncing, asynchronous button into a clean one-cycle trigger
// pulse per accepted press, plus a debounced level.
//
// Optional feature macro: TRIGGER_DEBOUNCER_AUTOREPEAT_EN
//   defined   - while the button stays pressed, trigger re-fires every
//               REPEAT_CYCLES cycles after the press pulse
//   undefined - exactly one trigger per accepted press, no repeat counter
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a press or release (>= 2)
//   REPEAT_CYCLES   - auto-repeat period while held (>= 2), used only with the macro
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-low reset
//   btn     in   raw button, asynchronous, active-high
//   trigger out  registered one-cycle pulse per accepted event
//   btn_db  out  registered debounced button level

module trigger_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic trigger,
   output logic btn_db
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("trigger_debouncer: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   state_t          state, state_next;
   logic [DB_W-1:0] cnt, cnt_next;
   logic            s1, btn_sync;
   logic            press_evt;
   logic            fire;
   logic            btn_db_next;

   // Two-flop synchronizer; nothing downstream looks at btn or s1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1       <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         s1       <= btn;
         btn_sync <= s1;
      end
   end

   // Every state change clears the debounce counter, so a bounce in either
   // WAIT state forces a fresh full run of stable samples.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      press_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_sync) begin
               state_next = WAIT_PRESS;
               cnt_next   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!btn_sync) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
               press_evt  = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_next = WAIT_RELEASE;
               cnt_next   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (btn_sync) begin
               // Release bounce: go back to PRESSED without a new press pulse.
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign btn_db_next = (state_next == PRESSED) || (state_next == WAIT_RELEASE);

`ifdef TRIGGER_DEBOUNCER_AUTOREPEAT_EN
   localparam int RP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

   logic [RP_W-1:0] rcnt, rcnt_next;
   logic            repeat_evt;

   // Counts only while remaining in PRESSED; any entry into PRESSED (from
   // WAIT_PRESS or a release bounce) and every other state leaves it at 0.
   always_comb begin
      rcnt_next  = '0;
      repeat_evt = 1'b0;
      if (state == PRESSED && state_next == PRESSED) begin
         if (rcnt == RP_LAST) begin
            repeat_evt = 1'b1;
         end else begin
            rcnt_next = rcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rcnt <= '0;
      end else begin
         rcnt <= rcnt_next;
      end
   end

   assign fire = press_evt | repeat_evt;
`else
   assign fire = press_evt;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         trigger <= 1'b0;
         btn_db  <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         trigger <= fire;
         btn_db  <= btn_db_next;
      end
   end

endmodule

// File: tb/tb_trigger_debouncer.sv
// tb/tb_trigger_debouncer.sv - self-checking bench for trigger_debouncer

module tb_trigger_debouncer;

   localparam int DEB = 8;
   localparam int REP = 20;
`ifdef TRIGGER_DEBOUNCER_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic btn;
   logic trigger;
   logic btn_db;

   trigger_debouncer #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn),
      .trigger(trigger),
      .btn_db (btn_db)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: run-length view of the synchronized button. The level
   // flips once DEB+1 consecutive synchronized samples disagree with it.
   logic m_s1, m_sync, m_db, m_trig;
   int   m_run, m_rep;

   typedef struct {
      logic b;
      logic r;
      logic et;
      logic ed;
   } vec_t;

   vec_t tbl[91];

   task automatic model_update(input logic b, input logic r);
      logic samp;
      logic stay;
      if (!r) begin
         m_s1 = 1'b0; m_sync = 1'b0; m_db = 1'b0; m_trig = 1'b0;
         m_run = 0; m_rep = 0;
      end else begin
         samp   = m_sync;
         m_sync = m_s1;
         m_s1   = b;
         m_trig = 1'b0;
         stay   = m_db && (m_run == 0) && samp;
         if (stay) begin
            m_rep = m_rep + 1;
            if (m_rep == REP) begin
               m_rep = 0;
               if (AR) m_trig = 1'b1;
            end
         end else begin
            m_rep = 0;
         end
         if (samp != m_db) begin
            m_run = m_run + 1;
            if (m_run == DEB + 1) begin
               m_db  = samp;
               m_run = 0;
               if (samp) m_trig = 1'b1;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic step(input logic b, input logic r);
      btn   = b;
      reset = r;
      @(posedge clk);
      model_update(b, r);
      #1;
   endtask

   task automatic check(input string name, input logic got, input logic exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s got=%b expected=%b at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic check_both(input string name, input logic et, input logic ed);
      check({name, ".trigger"}, trigger, et);
      check({name, ".btn_db"}, btn_db, ed);
   endtask

   initial begin
      logic pat[6];
      logic rb;
      logic rr;
      int   hold;

      btn   = 1'b0;
      reset = 1'b0;

      // Reset with btn held, release while held, then let go; then a clean
      // 40-cycle press and release.
      for (int i = 0; i < 91; i++) begin
         tbl[i].r  = 1'b1;
         tbl[i].et = 1'b0;
         tbl[i].ed = 1'b0;
         if (i < 3) begin
            tbl[i].b = 1'b1;
            tbl[i].r = 1'b0;
         end else if (i < 18) begin
            tbl[i].b  = 1'b1;
            tbl[i].et = (i == 13);
            tbl[i].ed = (i >= 13);
         end else if (i < 32) begin
            tbl[i].b  = 1'b0;
            tbl[i].ed = (i < 28);
         end else if (i < 36) begin
            tbl[i].b = 1'b0;
         end else if (i < 76) begin
            tbl[i].b  = 1'b1;
            tbl[i].et = (i == 46) || (AR && i == 66);
            tbl[i].ed = (i >= 46);
         end else begin
            tbl[i].b  = 1'b0;
            tbl[i].ed = (i < 86);
         end
      end

      for (int i = 0; i < 91; i++) begin
         step(tbl[i].b, tbl[i].r);
         check_both($sformatf("table[%0d]", i), tbl[i].et, tbl[i].ed);
      end

      // Bounce on press: 1,0,1,1,0,1 then steady high.
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
      pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
      for (int i = 0; i < 26; i++) begin
         step((i < 6) ? pat[i] : 1'b1, 1'b1);
         check_both($sformatf("bounce[%0d]", i), (i == 15), (i >= 15));
      end

      // Release bounce: 3 low cycles while held.
      for (int i = 0; i < 23; i++) begin
         step((i < 3) ? 1'b0 : 1'b1, 1'b1);
         check_both($sformatf("rel_bounce[%0d]", i), 1'b0, 1'b1);
      end
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b1);
         check_both($sformatf("release1[%0d]", i), 1'b0, (i < 10));
      end

      // Glitch: 7-cycle high pulse must be rejected.
      for (int i = 0; i < 22; i++) begin
         step((i < 7) ? 1'b1 : 1'b0, 1'b1);
         check_both($sformatf("glitch[%0d]", i), 1'b0, 1'b0);
      end

      // Long hold: press pulse at 10, repeats at +20/+40/+60 only with auto-repeat.
      for (int i = 0; i < 81; i++) begin
         step(1'b1, 1'b1);
         check_both($sformatf("hold[%0d]", i),
                    (i == 10) || (AR && (i == 30 || i == 50 || i == 70)), (i >= 10));
      end
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b1);
         check_both($sformatf("release2[%0d]", i), 1'b0, (i < 10));
      end

      // Random bursty stimulus with occasional resets against the model.
      rb   = 1'b0;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            rb   = ~rb;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 12);
         end
         hold = hold - 1;
         rr   = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         step(rb, rr);
         check_both($sformatf("rand[%0d]", i), m_trig, m_db);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
